// File: rtl/receiver_if.sv
// ---------------------------------------------------------------------------
// receiver_if -- bundled-data four-phase link between a sender and the
// receiver block.
//
//   data_in       sender -> receiver  bundled word, stable while req is high
//   req           sender -> receiver  four-phase request (asynchronous)
//   ack           receiver -> sender  four-phase acknowledge
//   receive_data  receiver -> user    last captured word
//   valid         receiver -> user    one-cycle pulse on each new capture
//
// Modports: master = sender/observer side, slave = receiver side.
// ---------------------------------------------------------------------------
interface receiver_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             req;
    logic             ack;
    logic [WIDTH-1:0] receive_data;
    logic             valid;

    modport master (
        output data_in,
        output req,
        input  ack,
        input  receive_data,
        input  valid
    );

    modport slave (
        input  data_in,
        input  req,
        output ack,
        output receive_data,
        output valid
    );
endinterface

// File: rtl/receiver.sv
// ---------------------------------------------------------------------------
// receiver -- clock-domain receiver for a four-phase bundled-data handshake.
//
// The asynchronous req is brought into the clk domain through a
// SYNC_STAGES-deep flop chain. A two-state FSM captures data_in once per
// req high phase, raises ack, pulses valid for one cycle, and lowers ack
// again once the synchronized req has returned low.
//
// Ports:
//   clk   receive-side clock, all state changes on its rising edge
//   rst   asynchronous active-low reset (0 = reset); release is expected
//         to be synchronous to clk
//   bus   receiver_if.slave: data_in/req in, ack/receive_data/valid out
//
// Parameters:
//   WIDTH        data width, 1..64 (must match the interface WIDTH)
//   SYNC_STAGES  req synchronizer depth, 2..4
// ---------------------------------------------------------------------------
module receiver #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    receiver_if.slave  bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACKED = 1'b1;

    logic [SYNC_STAGES-1:0] req_sync_p0;
    logic                   req_s;
    logic                   req_hi;

    logic [0:0]             state_p1;
    logic                   ack_p1;
    logic                   valid_p1;
    logic [WIDTH-1:0]       data_p1;

    // ---- Stage p0: req synchronizer (the only consumer of raw req) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_sync_p0 <= '0;
        end else begin
            req_sync_p0 <= {req_sync_p0[SYNC_STAGES-2:0], bus.req};
        end
    end

    assign req_s  = req_sync_p0[SYNC_STAGES-1];
    // An unknown synchronizer output is treated as a low request.
    assign req_hi = (req_s === 1'b1);

    // ---- Stage p1: handshake FSM, capture register and outputs ----
    // data_in is sampled directly on the capture edge: the sender holds it
    // stable for the whole req high phase, so it needs no synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1 <= IDLE;
            ack_p1   <= 1'b0;
            valid_p1 <= 1'b0;
            data_p1  <= '0;
        end else begin
            valid_p1 <= 1'b0;
            case (state_p1)
                IDLE: begin
                    if (req_hi) begin
                        data_p1  <= bus.data_in;
                        ack_p1   <= 1'b1;
                        valid_p1 <= 1'b1;
                        state_p1 <= ACKED;
                    end
                end
                ACKED: begin
                    // Stay here until req_s drops, so a long req phase
                    // yields exactly one capture.
                    if (!req_hi) begin
                        ack_p1   <= 1'b0;
                        state_p1 <= IDLE;
                    end
                end
                default: begin
                    ack_p1   <= 1'b0;
                    state_p1 <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack          = ack_p1;
    assign bus.valid        = valid_p1;
    assign bus.receive_data = data_p1;

endmodule

// File: tb/tb_receiver.sv
// ---------------------------------------------------------------------------
// tb_receiver -- scoreboard bench for receiver.
//
// The sender side pushes each word it expects to be captured into exp_q;
// an independent monitor pops and compares whenever valid is seen.
// Handshake timing is checked against the fixed synchronizer latency:
// with req driven just before edge N, ack/receive_data update at N+2,
// and with req dropped just before edge M, ack falls at M+2.
// ---------------------------------------------------------------------------
module tb_receiver;

    logic clk = 1'b1;
    logic rst;

    always #10 clk = ~clk;

    receiver_if #(.WIDTH(32)) bus ();

    receiver #(
        .WIDTH       (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          n_valid = 0;
    int          n_capt  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: every valid pulse must consume exactly one expected word.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst === 1'b1 && bus.valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: receive_data=%h, no capture outstanding (t=%0t)",
                         bus.receive_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("capture_data", {32'h0, bus.receive_data}, {32'h0, e});
            end
        end
    end

    // Full four-phase cycle; starts and ends just after a falling edge.
    task automatic handshake(input logic [31:0] d, input int hold);
        bus.data_in = d;
        bus.req     = 1'b1;
        exp_q.push_back(d);
        n_capt++;
        repeat (2) @(negedge clk);
        chk("ack_before_capture", bus.ack, 1'b0);
        chk("data_before_capture", bus.receive_data, last_word);
        @(negedge clk);
        chk("ack_rise", bus.ack, 1'b1);
        chk("valid_at_capture", bus.valid, 1'b1);
        last_word = d;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("ack_hold", bus.ack, 1'b1);
            chk("valid_hold", bus.valid, 1'b0);
            chk("data_hold", bus.receive_data, d);
        end
        bus.req = 1'b0;
        repeat (2) @(negedge clk);
        chk("ack_before_fall", bus.ack, 1'b1);
        @(negedge clk);
        chk("ack_fall", bus.ack, 1'b0);
        chk("data_after_fall", bus.receive_data, d);
        bus.data_in = $urandom();
    endtask

    // req pulse that never straddles a rising edge must be ignored.
    task automatic glitch();
        @(posedge clk);
        #3;
        bus.data_in = $urandom();
        bus.req     = 1'b1;
        #5;
        bus.req     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("glitch_ack", bus.ack, 1'b0);
            chk("glitch_data", bus.receive_data, last_word);
        end
    endtask

    // Reset while ACKED with req held high, then a fresh capture.
    task automatic reset_mid();
        bus.data_in = 32'hDEADBEEF;
        bus.req     = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        n_capt++;
        repeat (3) @(negedge clk);
        chk("mid_ack_before_reset", bus.ack, 1'b1);
        last_word = 32'hDEADBEEF;
        @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        chk("mid_reset_ack", bus.ack, 1'b0);
        chk("mid_reset_valid", bus.valid, 1'b0);
        chk("mid_reset_data", bus.receive_data, 32'h0);
        last_word = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(32'hDEADBEEF);
        n_capt++;
        repeat (2) @(negedge clk);
        chk("post_reset_ack_early", bus.ack, 1'b0);
        chk("post_reset_data_early", bus.receive_data, 32'h0);
        @(negedge clk);
        chk("post_reset_ack_rise", bus.ack, 1'b1);
        chk("post_reset_valid", bus.valid, 1'b1);
        last_word = 32'hDEADBEEF;
        bus.req = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_ack_fall", bus.ack, 1'b0);
    endtask

    initial begin
        rst         = 1'b0;
        bus.req     = 1'b0;
        bus.data_in = '0;
        last_word   = '0;

        #5;
        chk("reset_ack", bus.ack, 1'b0);
        chk("reset_valid", bus.valid, 1'b0);
        chk("reset_data", bus.receive_data, 32'h0);
        #25;
        rst = 1'b1;
        #1;
        chk("release_ack", bus.ack, 1'b0);
        chk("release_data", bus.receive_data, 32'h0);
        repeat (3) @(negedge clk);
        chk("idle_ack", bus.ack, 1'b0);
        chk("idle_valid", bus.valid, 1'b0);

        handshake(32'h0000CDEF, 0);
        handshake(32'h12345678, 20);
        handshake(32'hAAAA5555, 0);
        handshake(32'h5555AAAA, 0);
        glitch();
        reset_mid();

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 2) == 0) glitch();
            handshake($urandom(), $urandom_range(0, 6));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("valid_count", n_valid, n_capt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
